predictor_update_scheduler: RTL and testbench
=============================================

# predictor_update_scheduler

Sequences all writes into the 2-bit branch-history counter table of the branch predictor. Commit-time branch outcomes from the ReorderBuffer are buffered in a small FIFO and drained to the table one per cycle. On request, a clear sequencer walks every table index and re-initialises it to weakly-not-taken. The block sits between ReorderBuffer and Predictor and owns the predictor's single table write port.

## Interface
- `DEPTH`, 4: outcome FIFO entries (power of two, ≥2)
- `PDC_SIZE`, 256: counter-table entries
- `INDEX_BITS`, 8: log2(PDC_SIZE); index = pc[INDEX_BITS+1 : 2]
- `clk`  in  1  clock; all state updates on posedge
- `rst`  in  1  synchronous reset, active-high
- `rdy`  in  1  global ready; low freezes the block
- `ROB_input_valid`  in  1  branch outcome offered this cycle
- `ROB_hit`  in  1  outcome was taken
- `ROB_pc`  in  `AddrWidth`  pc of the resolved branch
- `ROB_full`  out  1  FIFO full; combinational (count == DEPTH)
- `CLR_req`  in  1  pulse that requests a full-table clear
- `CLR_busy`  out  1  registered; high while in state CLEAR
- `PDC_upd_valid`  out  1  registered; table write this cycle
- `PDC_upd_init`  out  1  registered; 1 = write 2'b01, 0 = saturating train
- `PDC_upd_hit`  out  1  registered; train direction (0 when init)
- `PDC_upd_index`  out  INDEX_BITS  registered; table index
- `drop_count`  out  8  registered; saturating count of outcomes lost while full

## Operation
- FIFO: circular, head/tail pointers with wrap at DEPTH, count register 0..DEPTH. Each entry stores {hit, index}. Only the index bits of the pc are kept.
- Enqueue: on a posedge with rdy=1, ROB_input_valid=1 and count<DEPTH (count taken before the edge), store the entry at the tail.
- Drop: on a posedge with rdy=1, ROB_input_valid=1 and count==DEPTH, the entry is discarded and drop_count increments. drop_count saturates at 255. There is no bypass: a pop in the same edge does not make room.
- FSM states:
  - DRAIN (reset state): if count>0, pop the head and load PDC_upd_valid=1, init=0, hit and index from the entry; otherwise load PDC_upd_valid=0.
  - DRAIN→CLEAR: CLR_req=1 at a posedge while in DRAIN. The clear index is set to 0, and no pop happens on that edge.
  - CLEAR: each edge loads PDC_upd_valid=1, init=1, hit=0, index=clear index, then increments the clear index.
  - CLEAR→DRAIN: on the edge that emits index PDC_SIZE-1. Exactly PDC_SIZE init writes are issued, in increasing index order.
- CLR_req while in CLEAR: ignored; the clear is not restarted.
- FIFO during CLEAR: enqueue and drop continue as normal; no pops. Queued outcomes drain only after the clear finishes.
- Simultaneous enqueue and pop: count is unchanged.
- Index arithmetic: head, tail and clear index are unsigned and wrap modulo their range.
- rdy=0: every register holds, including outputs. ROB_input_valid and CLR_req are ignored (a CLR_req pulse during rdy=0 is lost).
- rst=1: count=0, head=tail=0, state DRAIN, clear index 0, drop_count 0, PDC_upd_valid/init/hit=0, PDC_upd_index=0, CLR_busy=0. Reset in the middle of a clear abandons the clear immediately.

## Timing
- Empty-FIFO latency: an outcome enqueued at edge E is popped at edge E+1, so PDC_upd_valid is high during cycle E+1..E+2 (two edges).
- Throughput: one table write per cycle in both states.
- CLR_busy rises one edge after the CLR_req edge and stays high for PDC_SIZE cycles. It falls on the edge after the last init write is loaded, coinciding with the first possible pop.
- ROB_full is combinational from count, so the ReorderBuffer sees it in the same cycle it offers an outcome.

## Test plan
- Reset, then a single outcome (hit=1, pc=0x1008) enqueued at edge 1 → exactly one cycle with PDC_upd_valid=1, index=0x02, hit=1, init=0 after edge 2. Valid=0 afterwards.
- Back-to-back outcomes on 6 consecutive cycles with DEPTH=4 and the FSM held in CLEAR → ROB_full=1 after 4 enqueues, drop_count=2. After the clear, the 4 stored entries drain in FIFO order.
- CLR_req once with the FIFO empty → CLR_busy high for 256 cycles. Init writes cover indices 0..255 in order with init=1. A second CLR_req at mid-clear changes nothing.
- Enqueue and pop on the same edge for 20 cycles with count=2 → count stays 2 and output order matches input order across pointer wrap.
- rdy=0 for 5 cycles mid-drain with ROB_input_valid=1 → outputs and count frozen, nothing enqueued or dropped. Draining resumes exactly where it stopped.
- rst asserted at clear index 100 → next cycle state DRAIN, CLR_busy=0, PDC_upd_valid=0, count=0.

Source files
------------

// File: rtl/predictor_update_scheduler.sv
// Single writer for the branch predictor's 2-bit counter table: drains buffered
// commit-time outcomes one per cycle, or walks the whole table re-initialising it.
module predictor_update_scheduler #(
    parameter int DEPTH      = 4,
    parameter int PDC_SIZE   = 256,
    parameter int INDEX_BITS = 8,
    parameter int AddrWidth  = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  rdy,
    input  logic                  ROB_input_valid,
    input  logic                  ROB_hit,
    input  logic [AddrWidth-1:0]  ROB_pc,
    output logic                  ROB_full,
    input  logic                  CLR_req,
    output logic                  CLR_busy,
    output logic                  PDC_upd_valid,
    output logic                  PDC_upd_init,
    output logic                  PDC_upd_hit,
    output logic [INDEX_BITS-1:0] PDC_upd_index,
    output logic [7:0]            drop_count
);

    localparam int PTR_BITS = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_BITS = PTR_BITS + 1;

    typedef enum logic {DRAIN, CLEAR} state_t;

    state_t                state_reg;
    logic [PTR_BITS-1:0]   head_reg;
    logic [PTR_BITS-1:0]   tail_reg;
    logic [CNT_BITS-1:0]   count_reg;
    logic [INDEX_BITS-1:0] clr_idx_reg;
    logic                  busy_reg;
    logic                  upd_valid_reg;
    logic                  upd_init_reg;
    logic                  upd_hit_reg;
    logic [INDEX_BITS-1:0] upd_index_reg;
    logic [7:0]            drop_count_reg;

    // Each entry is {hit, index}; the rest of the pc is never needed.
    logic [INDEX_BITS:0]   fifo_mem [DEPTH];
    logic [INDEX_BITS:0]   head_entry;

    logic fifo_full;
    logic fifo_empty;
    logic push;
    logic pop;
    logic drop;
    logic unused_pc_bits;

    assign unused_pc_bits = ^{ROB_pc[AddrWidth-1:INDEX_BITS+2], ROB_pc[1:0]};

    assign fifo_full  = (count_reg == CNT_BITS'(DEPTH));
    assign fifo_empty = (count_reg == '0);
    assign push       = rdy && ROB_input_valid && !fifo_full;
    assign drop       = rdy && ROB_input_valid && fifo_full;
    // The edge that accepts CLR_req never pops, so the head waits until the clear is done.
    assign pop        = rdy && (state_reg == DRAIN) && !CLR_req && !fifo_empty;
    assign head_entry = fifo_mem[head_reg];

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem[tail_reg] <= {ROB_hit, ROB_pc[INDEX_BITS+1:2]};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg      <= DRAIN;
            head_reg       <= '0;
            tail_reg       <= '0;
            count_reg      <= '0;
            clr_idx_reg    <= '0;
            busy_reg       <= 1'b0;
            upd_valid_reg  <= 1'b0;
            upd_init_reg   <= 1'b0;
            upd_hit_reg    <= 1'b0;
            upd_index_reg  <= '0;
            drop_count_reg <= '0;
        end else if (rdy) begin
            if (push) begin
                tail_reg <= tail_reg + PTR_BITS'(1);
            end
            if (pop) begin
                head_reg <= head_reg + PTR_BITS'(1);
            end
            if (push && !pop) begin
                count_reg <= count_reg + CNT_BITS'(1);
            end else if (pop && !push) begin
                count_reg <= count_reg - CNT_BITS'(1);
            end
            if (drop && drop_count_reg != 8'hFF) begin
                drop_count_reg <= drop_count_reg + 8'd1;
            end

            // Busy trails the state by one edge so it drops exactly when pops may resume.
            busy_reg <= (state_reg == CLEAR);

            case (state_reg)
                DRAIN: begin
                    if (CLR_req) begin
                        state_reg     <= CLEAR;
                        clr_idx_reg   <= '0;
                        upd_valid_reg <= 1'b0;
                    end else if (!fifo_empty) begin
                        upd_valid_reg <= 1'b1;
                        upd_init_reg  <= 1'b0;
                        upd_hit_reg   <= head_entry[INDEX_BITS];
                        upd_index_reg <= head_entry[INDEX_BITS-1:0];
                    end else begin
                        upd_valid_reg <= 1'b0;
                    end
                end
                CLEAR: begin
                    upd_valid_reg <= 1'b1;
                    upd_init_reg  <= 1'b1;
                    upd_hit_reg   <= 1'b0;
                    upd_index_reg <= clr_idx_reg;
                    clr_idx_reg   <= clr_idx_reg + INDEX_BITS'(1);
                    if (clr_idx_reg == INDEX_BITS'(PDC_SIZE - 1)) begin
                        state_reg <= DRAIN;
                    end
                end
                default: state_reg <= DRAIN;
            endcase
        end
    end

    assign ROB_full      = fifo_full;
    assign CLR_busy      = busy_reg;
    assign PDC_upd_valid = upd_valid_reg;
    assign PDC_upd_init  = upd_init_reg;
    assign PDC_upd_hit   = upd_hit_reg;
    assign PDC_upd_index = upd_index_reg;
    assign drop_count    = drop_count_reg;

endmodule

// File: tb/tb_predictor_update_scheduler.sv
// Randomised bench for predictor_update_scheduler against a queue-based model
// of the outcome buffer, the table clear walk and the drop counter.
module tb_predictor_update_scheduler;

    localparam int DEPTH      = 4;
    localparam int PDC_SIZE   = 256;
    localparam int INDEX_BITS = 8;
    localparam int AddrWidth  = 32;

    logic                  clk = 1'b0;
    logic                  rst;
    logic                  rdy;
    logic                  ROB_input_valid;
    logic                  ROB_hit;
    logic [AddrWidth-1:0]  ROB_pc;
    logic                  ROB_full;
    logic                  CLR_req;
    logic                  CLR_busy;
    logic                  PDC_upd_valid;
    logic                  PDC_upd_init;
    logic                  PDC_upd_hit;
    logic [INDEX_BITS-1:0] PDC_upd_index;
    logic [7:0]            drop_count;

    predictor_update_scheduler #(
        .DEPTH(DEPTH), .PDC_SIZE(PDC_SIZE), .INDEX_BITS(INDEX_BITS), .AddrWidth(AddrWidth)
    ) dut (
        .clk(clk), .rst(rst), .rdy(rdy),
        .ROB_input_valid(ROB_input_valid), .ROB_hit(ROB_hit), .ROB_pc(ROB_pc),
        .ROB_full(ROB_full), .CLR_req(CLR_req), .CLR_busy(CLR_busy),
        .PDC_upd_valid(PDC_upd_valid), .PDC_upd_init(PDC_upd_init),
        .PDC_upd_hit(PDC_upd_hit), .PDC_upd_index(PDC_upd_index),
        .drop_count(drop_count)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("FAIL %s observed=%0h expected=%0h at %0t", tag, observed, expected, $time);
        end
    endtask

    // Model: the buffer is a plain queue, the clear is "positions still to emit".
    int unsigned mq[$];
    bit m_clearing;
    int m_clr_pos;
    bit m_busy;
    bit m_valid, m_init, m_hit;
    int m_idx;
    int m_drops;

    task automatic model_step(input bit r, input bit rd, input bit v, input bit h,
                              input logic [31:0] pc, input bit clr);
        int n;
        int unsigned e;
        if (r) begin
            mq.delete();
            m_clearing = 0; m_clr_pos = 0; m_busy = 0;
            m_valid = 0; m_init = 0; m_hit = 0; m_idx = 0; m_drops = 0;
        end else if (rd) begin
            n = mq.size();
            m_busy = m_clearing;
            if (m_clearing) begin
                m_valid = 1; m_init = 1; m_hit = 0; m_idx = m_clr_pos;
                m_clr_pos++;
                if (m_clr_pos == PDC_SIZE) m_clearing = 0;
            end else if (clr) begin
                m_clearing = 1; m_clr_pos = 0; m_valid = 0;
            end else if (n > 0) begin
                e = mq.pop_front();
                m_valid = 1; m_init = 0; m_hit = e[8]; m_idx = int'(e[7:0]);
                $display("XFER idx=%02h hit=%0d", m_idx, m_hit);
            end else begin
                m_valid = 0;
            end
            if (v) begin
                if (n < DEPTH) mq.push_back({23'd0, h, pc[INDEX_BITS+1:2]});
                else if (m_drops < 255) m_drops++;
            end
        end
    endtask

    task automatic compare_all();
        check("valid", PDC_upd_valid, m_valid);
        check("busy", CLR_busy, m_busy);
        check("full", ROB_full, mq.size() == DEPTH);
        check("drops", drop_count, m_drops);
        if (m_valid) begin
            check("init", PDC_upd_init, m_init);
            check("hit", PDC_upd_hit, m_hit);
            check("index", PDC_upd_index, m_idx);
        end
    endtask

    task automatic cycle(input bit r, input bit rd, input bit v, input bit h,
                         input logic [31:0] pc, input bit clr);
        rst = r; rdy = rd; ROB_input_valid = v; ROB_hit = h; ROB_pc = pc; CLR_req = clr;
        @(posedge clk);
        model_step(r, rd, v, h, pc, clr);
        #1;
        compare_all();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(0, 1, 0, 0, 32'd0, 0);
    endtask

    initial begin
        rst = 1; rdy = 1; ROB_input_valid = 0; ROB_hit = 0; ROB_pc = '0; CLR_req = 0;
        cycle(1, 1, 0, 0, 32'd0, 0);
        cycle(1, 1, 0, 0, 32'd0, 0);
        check("rst_index", PDC_upd_index, 0);
        check("rst_init", PDC_upd_init, 0);
        check("rst_hit", PDC_upd_hit, 0);

        // Single outcome on an empty buffer.
        cycle(0, 1, 1, 1, 32'h1008, 0);
        cycle(0, 1, 0, 0, 32'd0, 0);
        check("single_index", PDC_upd_index, 8'h02);
        check("single_valid", PDC_upd_valid, 1);
        idle(3);

        // Clear with six back-to-back outcomes queued behind it, plus an ignored mid-clear request.
        cycle(0, 1, 0, 0, 32'd0, 1);
        for (int i = 0; i < PDC_SIZE; i++)
            cycle(0, 1, i < 6, 1'($urandom), $urandom, i == 128);
        check("fill_drops", drop_count, 2);
        idle(8);

        // Steady state with two entries: push and pop every edge across pointer wrap.
        cycle(0, 1, 0, 0, 32'd0, 1);
        for (int i = 0; i < PDC_SIZE; i++)
            cycle(0, 1, i >= PDC_SIZE - 2, 1'($urandom), $urandom, 0);
        for (int i = 0; i < 20; i++) cycle(0, 1, 1, 1'($urandom), $urandom, 0);

        // Freeze mid-drain with outcomes offered.
        for (int i = 0; i < 5; i++) cycle(0, 0, 1, 1'($urandom), $urandom, i == 2);
        idle(6);

        // Reset in the middle of a clear.
        cycle(0, 1, 0, 0, 32'd0, 1);
        for (int i = 0; i < 100; i++) cycle(0, 1, 1'($urandom), 1'($urandom), $urandom, 0);
        cycle(1, 1, 1, 1, 32'h44, 0);
        check("rst_mid_busy", CLR_busy, 0);
        check("rst_mid_valid", PDC_upd_valid, 0);
        idle(3);

        // Random traffic.
        for (int i = 0; i < 2500; i++)
            cycle(($urandom % 700) == 0, ($urandom % 8) != 0, 1'($urandom),
                  1'($urandom), $urandom, ($urandom % 400) == 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
